// File: rtl/sc_collision_scheduler_pkg.sv
// Shared types and defaults for the collision scheduler: FSM encoding,
// matrix geometry defaults and the row-index width derived from them.
package sc_collision_scheduler_pkg;

  localparam int DEFAULT_DATAWIDTH = 8;
  localparam int DEFAULT_ROWS      = 8;
  localparam int ROW_IDX_W         = $clog2(DEFAULT_ROWS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    CMP1  = 3'd2,
    CMP2  = 3'd3,
    DONE  = 3'd4
  } scanState_t;

endpackage

// File: rtl/sc_collision_rowcounter.sv
// Row index counter for the matrix scan: synchronous clear, increment that
// saturates at the last row, and a combinational last-row flag.
module sc_collision_rowcounter
  import sc_collision_scheduler_pkg::*;
#(
  parameter int ROWS = DEFAULT_ROWS,
  parameter int ROWW = ROW_IDX_W
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            clr,
  input  logic            inc,
  output logic [ROWW-1:0] row,
  output logic            lastRow
);

  assign lastRow = (row == ROWW'(ROWS - 1));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      row <= '0;
    end else if (clr) begin
      row <= '0;
    end else if (inc && !lastRow) begin
      row <= row + 1'b1;
    end
  end

endmodule

// File: rtl/sc_collision_scheduler.sv
// Scans ROWS matrix rows through one shared external comparator, checking
// both player positions per row and latching each player's first matching row.
module sc_collision_scheduler
  import sc_collision_scheduler_pkg::*;
#(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
  parameter int ROWS      = DEFAULT_ROWS
) (
  input  logic                     SC_COLLISION_SCHEDULER_CLOCK_50,
  input  logic                     SC_COLLISION_SCHEDULER_RESET_InLow,
  input  logic                     SC_COLLISION_SCHEDULER_start_In,
  input  logic [DATAWIDTH-1:0]     SC_COLLISION_SCHEDULER_posjug1_In,
  input  logic [DATAWIDTH-1:0]     SC_COLLISION_SCHEDULER_posjug2_In,
  output logic [$clog2(ROWS)-1:0]  SC_COLLISION_SCHEDULER_rowsel_Out,
  input  logic [DATAWIDTH-1:0]     SC_COLLISION_SCHEDULER_rowdata_In,
  output logic [DATAWIDTH-1:0]     SC_COLLISION_SCHEDULER_cmpA_Out,
  output logic [DATAWIDTH-1:0]     SC_COLLISION_SCHEDULER_cmpB_Out,
  input  logic                     SC_COLLISION_SCHEDULER_cmpEq_In,
  output logic                     SC_COLLISION_SCHEDULER_busy_Out,
  output logic                     SC_COLLISION_SCHEDULER_done_Out,
  output logic                     SC_COLLISION_SCHEDULER_hitjug1_Out,
  output logic                     SC_COLLISION_SCHEDULER_hitjug2_Out,
  output logic [$clog2(ROWS)-1:0]  SC_COLLISION_SCHEDULER_rowjug1_Out,
  output logic [$clog2(ROWS)-1:0]  SC_COLLISION_SCHEDULER_rowjug2_Out
);

  localparam int ROWW = $clog2(ROWS);

  logic clk;
  logic rstN;
  assign clk  = SC_COLLISION_SCHEDULER_CLOCK_50;
  assign rstN = SC_COLLISION_SCHEDULER_RESET_InLow;

  scanState_t state, stateNext;

  logic [DATAWIDTH-1:0] pos1Snap, pos2Snap;
  logic                 hit1, hit2;
  logic [ROWW-1:0]      row1, row2;
  logic [ROWW-1:0]      row;
  logic                 lastRow;
  logic                 accept;
  logic                 scanning;

  assign accept   = (state == IDLE) && SC_COLLISION_SCHEDULER_start_In;
  assign scanning = (state == FETCH) || (state == CMP1) || (state == CMP2);

  sc_collision_rowcounter #(
    .ROWS (ROWS),
    .ROWW (ROWW)
  ) uRowCounter (
    .clk     (clk),
    .rstN    (rstN),
    .clr     (accept),
    .inc     (state == CMP2),
    .row     (row),
    .lastRow (lastRow)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (SC_COLLISION_SCHEDULER_start_In) stateNext = FETCH;
      FETCH:   stateNext = CMP1;
      CMP1:    stateNext = CMP2;
      CMP2:    stateNext = lastRow ? DONE : FETCH;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Comparator operands are forced to zero outside the compare states so the
  // shared comparator sees no stale traffic from this block.
  always_comb begin
    SC_COLLISION_SCHEDULER_cmpA_Out = '0;
    SC_COLLISION_SCHEDULER_cmpB_Out = '0;
    if (state == CMP1) begin
      SC_COLLISION_SCHEDULER_cmpA_Out = SC_COLLISION_SCHEDULER_rowdata_In;
      SC_COLLISION_SCHEDULER_cmpB_Out = pos1Snap;
    end else if (state == CMP2) begin
      SC_COLLISION_SCHEDULER_cmpA_Out = SC_COLLISION_SCHEDULER_rowdata_In;
      SC_COLLISION_SCHEDULER_cmpB_Out = pos2Snap;
    end
  end

  assign SC_COLLISION_SCHEDULER_rowsel_Out = scanning ? row : '0;
  assign SC_COLLISION_SCHEDULER_busy_Out   = scanning;
  assign SC_COLLISION_SCHEDULER_done_Out   = (state == DONE);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      pos1Snap <= '0;
      pos2Snap <= '0;
      hit1     <= 1'b0;
      hit2     <= 1'b0;
      row1     <= '0;
      row2     <= '0;
    end else if (accept) begin
      pos1Snap <= SC_COLLISION_SCHEDULER_posjug1_In;
      pos2Snap <= SC_COLLISION_SCHEDULER_posjug2_In;
      hit1     <= 1'b0;
      hit2     <= 1'b0;
      row1     <= '0;
      row2     <= '0;
    end else begin
      // First match wins: once a hit is recorded the row index is frozen.
      if ((state == CMP1) && SC_COLLISION_SCHEDULER_cmpEq_In && !hit1) begin
        hit1 <= 1'b1;
        row1 <= row;
      end
      if ((state == CMP2) && SC_COLLISION_SCHEDULER_cmpEq_In && !hit2) begin
        hit2 <= 1'b1;
        row2 <= row;
      end
    end
  end

  assign SC_COLLISION_SCHEDULER_hitjug1_Out = hit1;
  assign SC_COLLISION_SCHEDULER_hitjug2_Out = hit2;
  assign SC_COLLISION_SCHEDULER_rowjug1_Out = row1;
  assign SC_COLLISION_SCHEDULER_rowjug2_Out = row2;

endmodule

// File: tb/tb_sc_collision_scheduler.sv
// Bench for sc_collision_scheduler: models the row memory and the shared
// comparator, runs a vector table of matrices plus hand-built corner sequences.
module tb_sc_collision_scheduler;

  logic       clk;
  logic       rstN;
  logic       start;
  logic [7:0] pos1, pos2;
  logic [2:0] rowsel;
  logic [7:0] rowdata;
  logic [7:0] cmpA, cmpB;
  logic       cmpEq;
  logic       busy, done;
  logic       hit1, hit2;
  logic [2:0] row1, row2;

  logic [7:0] mem [8];

  int total = 0;
  int bad   = 0;

  sc_collision_scheduler dut (
    .SC_COLLISION_SCHEDULER_CLOCK_50    (clk),
    .SC_COLLISION_SCHEDULER_RESET_InLow (rstN),
    .SC_COLLISION_SCHEDULER_start_In    (start),
    .SC_COLLISION_SCHEDULER_posjug1_In  (pos1),
    .SC_COLLISION_SCHEDULER_posjug2_In  (pos2),
    .SC_COLLISION_SCHEDULER_rowsel_Out  (rowsel),
    .SC_COLLISION_SCHEDULER_rowdata_In  (rowdata),
    .SC_COLLISION_SCHEDULER_cmpA_Out    (cmpA),
    .SC_COLLISION_SCHEDULER_cmpB_Out    (cmpB),
    .SC_COLLISION_SCHEDULER_cmpEq_In    (cmpEq),
    .SC_COLLISION_SCHEDULER_busy_Out    (busy),
    .SC_COLLISION_SCHEDULER_done_Out    (done),
    .SC_COLLISION_SCHEDULER_hitjug1_Out (hit1),
    .SC_COLLISION_SCHEDULER_hitjug2_Out (hit2),
    .SC_COLLISION_SCHEDULER_rowjug1_Out (row1),
    .SC_COLLISION_SCHEDULER_rowjug2_Out (row2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read matrix memory and the external shared comparator.
  always @(posedge clk) rowdata <= mem[rowsel];
  assign cmpEq = (cmpA == cmpB);

  typedef struct {
    logic [63:0] mat;
    logic [7:0]  p1;
    logic [7:0]  p2;
    logic        eh1;
    logic [2:0]  er1;
    logic        eh2;
    logic [2:0]  er2;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic loadMat(input logic [63:0] m);
    for (int r = 0; r < 8; r++) mem[r] = m[8*r +: 8];
  endtask

  // Called #1 after a rising edge with the DUT idle; returns #1 into the done cycle.
  task automatic runScan(output int doneCyc, output int busyCnt, output logic fetchClean);
    doneCyc    = 0;
    busyCnt    = 0;
    fetchClean = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 1) fetchClean = (cmpA == 8'h00) && (cmpB == 8'h00) && (rowsel == 3'd0) && busy;
      if (busy) busyCnt++;
      if (done) begin
        doneCyc = k;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  int   dc, bc, dc2, doneCount;
  logic fc;

  initial begin
    start = 1'b0;
    pos1  = 8'h00;
    pos2  = 8'h00;
    loadMat(64'h0);
    rowdata = 8'h00;
    rstN = 1'b1;
    #3 rstN = 1'b0;
    #9;
    chk("reset_busy",   busy,   0);
    chk("reset_done",   done,   0);
    chk("reset_hits",   {hit1, hit2}, 0);
    chk("reset_rows",   {row1, row2}, 0);
    chk("reset_rowsel", rowsel, 0);
    chk("reset_cmp",    {cmpA, cmpB}, 0);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk); #1;

    vecs[0] = '{64'h00810000_00810000, 8'h81, 8'h81, 1'b1, 3'd2, 1'b1, 3'd2};
    vecs[1] = '{64'h00000000_10000000, 8'h10, 8'h01, 1'b1, 3'd3, 1'b0, 3'd0};
    vecs[2] = '{64'h00000000_00000000, 8'h00, 8'hFF, 1'b1, 3'd0, 1'b0, 3'd0};
    vecs[3] = '{64'hAA070605_04030201, 8'h55, 8'hAA, 1'b0, 3'd0, 1'b1, 3'd7};
    vecs[4] = '{64'h3C11C311_1111113C, 8'h3C, 8'hC3, 1'b1, 3'd0, 1'b1, 3'd5};

    for (int v = 0; v < 5; v++) begin
      loadMat(vecs[v].mat);
      pos1 = vecs[v].p1;
      pos2 = vecs[v].p2;
      runScan(dc, bc, fc);
      chk($sformatf("v%0d_done_cycle", v), dc, 25);
      chk($sformatf("v%0d_busy_cycles", v), bc, 24);
      chk($sformatf("v%0d_fetch_clean", v), fc, 1);
      chk($sformatf("v%0d_done_cmp_zero", v), {cmpA, cmpB}, 0);
      chk($sformatf("v%0d_hit1", v), hit1, vecs[v].eh1);
      chk($sformatf("v%0d_row1", v), row1, vecs[v].er1);
      chk($sformatf("v%0d_hit2", v), hit2, vecs[v].eh2);
      chk($sformatf("v%0d_row2", v), row2, vecs[v].er2);
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_pulse_once", v), done, 0);
      chk($sformatf("v%0d_idle_cmp_zero", v), {cmpA, cmpB}, 0);
      chk($sformatf("v%0d_hold", v), {hit1, row1, hit2, row2},
          {vecs[v].eh1, vecs[v].er1, vecs[v].eh2, vecs[v].er2});
    end

    // start held high for 30 cycles: one scan, then a fresh accept from IDLE.
    loadMat(64'h00000000_10000000);
    pos1 = 8'h10;
    pos2 = 8'h01;
    dc = 0; dc2 = 0; doneCount = 0;
    start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 60; k++) begin
      if (k == 30) start = 1'b0;
      if (done) begin
        doneCount++;
        if (dc == 0) dc = k;
        else dc2 = k;
      end
      if (k == 26) chk("held_idle_gap", busy, 0);
      if (k == 27) chk("held_second_accept", busy, 1);
      @(posedge clk); #1;
    end
    chk("held_first_done", dc, 25);
    chk("held_second_done", dc2, 51);
    chk("held_done_count", doneCount, 2);
    chk("held_hits", {hit1, row1, hit2}, {1'b1, 3'd3, 1'b0});

    // Position inputs change mid-scan; the snapshot must be used.
    pos1 = 8'h10;
    pos2 = 8'h01;
    dc = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) begin
        pos1 = 8'h20;
        pos2 = 8'h10;
      end
      if (done) begin
        dc = k;
        break;
      end
      @(posedge clk); #1;
    end
    chk("snap_done_cycle", dc, 25);
    chk("snap_hit1_row1", {hit1, row1}, {1'b1, 3'd3});
    chk("snap_hit2", hit2, 0);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a scan.
    loadMat(64'h0);
    pos1 = 8'h00;
    pos2 = 8'h5A;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k < 12; k++) begin
      @(posedge clk); #1;
    end
    chk("mid_hit1_before_reset", hit1, 1);
    chk("mid_rowsel_before_reset", rowsel, 3);
    rstN = 1'b0;
    #1;
    chk("mid_reset_busy_done", {busy, done}, 0);
    chk("mid_reset_hits", {hit1, hit2, row1, row2}, 0);
    chk("mid_reset_rowsel", rowsel, 0);
    chk("mid_reset_cmp", {cmpA, cmpB}, 0);
    #1 rstN = 1'b1;
    @(posedge clk); #1;
    runScan(dc, bc, fc);
    chk("post_reset_done_cycle", dc, 25);
    chk("post_reset_busy_cycles", bc, 24);
    chk("post_reset_fetch_row0", fc, 1);
    chk("post_reset_hits", {hit1, row1, hit2, row2}, {1'b1, 3'd0, 1'b0, 3'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sc_collision_scheduler.md
SC_COLLISION_SCHEDULER -- requirements
Module: sc_collision_scheduler

Interface
REQ-001 Parameter DATAWIDTH, default 8: width of a matrix row and of a player position word.
REQ-002 Parameter ROWS, default 8: number of matrix rows scanned; row index width = clog2(ROWS) (3 at default).
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 SC_COLLISION_SCHEDULER_CLOCK_50  in  1  system clock; all state changes on its rising edge.
REQ-005 SC_COLLISION_SCHEDULER_RESET_InLow  in  1  asynchronous active-low reset.
REQ-006 SC_COLLISION_SCHEDULER_start_In  in  1  scan request, sampled per cycle.
REQ-007 SC_COLLISION_SCHEDULER_posjug1_In  in  DATAWIDTH  player 1 position word.
REQ-008 SC_COLLISION_SCHEDULER_posjug2_In  in  DATAWIDTH  player 2 position word.
REQ-009 SC_COLLISION_SCHEDULER_rowsel_Out  out  3  row index to matrix memory.
REQ-010 SC_COLLISION_SCHEDULER_rowdata_In  in  DATAWIDTH  row contents; valid from the cycle after rowsel_Out changes, while it is held.
REQ-011 SC_COLLISION_SCHEDULER_cmpA_Out, _cmpB_Out  out  DATAWIDTH each  operands to the single shared position comparator.
REQ-012 SC_COLLISION_SCHEDULER_cmpEq_In  in  1  combinational equality result from the shared comparator.
REQ-013 SC_COLLISION_SCHEDULER_busy_Out  out  1  high while a scan is in progress.
REQ-014 SC_COLLISION_SCHEDULER_done_Out  out  1  one-cycle pulse at scan completion.
REQ-015 SC_COLLISION_SCHEDULER_hitjug1_Out, _hitjug2_Out  out  1 each  player matched at least one row.
REQ-016 SC_COLLISION_SCHEDULER_rowjug1_Out, _rowjug2_Out  out  3 each  lowest matching row per player.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, CMP1, CMP2, DONE.
REQ-018 The FSM SHALL accept start_In only in IDLE; start_In in any other state SHALL be ignored.
REQ-019 On acceptance it SHALL snapshot posjug1_In/posjug2_In, clear all hit/row outputs, set row=0 and enter FETCH.
REQ-020 FETCH SHALL drive rowsel_Out=row and enter CMP1; rowsel_Out SHALL hold through CMP1 and CMP2.
REQ-021 CMP1 SHALL drive cmpA=rowdata_In, cmpB=pos1 snapshot; CMP2 SHALL drive cmpB=pos2 snapshot; in all other states cmpA=cmpB=0.
REQ-022 cmpEq_In SHALL be sampled at the end of CMP1 (player 1) and CMP2 (player 2).
REQ-023 On first match per player, hit flag SHALL set and row index latch; later matches SHALL NOT overwrite.
REQ-024 After CMP2: if row==ROWS-1 enter DONE, else row+1 and FETCH; no wrap-around past ROWS-1.
REQ-025 DONE SHALL pulse done_Out for exactly one cycle and return to IDLE.
REQ-026 Latency: start sampled at cycle 0 -> done_Out high in cycle 3*ROWS+1 (25 at default); busy_Out high cycles 1..3*ROWS.
REQ-027 Hit/row outputs SHALL hold their values from DONE until the next accepted start.
REQ-028 With no match, hit flag SHALL be 0 and row output 0.
REQ-029 Input position changes during a scan SHALL have no effect (snapshot only).

Reset
REQ-030 Reset assertion SHALL, asynchronously and at any state including mid-scan, force IDLE, row=0, and all outputs to 0.
REQ-031 After deassertion the first accepted start SHALL begin a full scan from row 0.

Structure
REQ-032 Shared package SHALL hold state encoding, DATAWIDTH/ROWS defaults and row-index width constant.
REQ-033 Row index counter SHALL be a sub-module sc_collision_rowcounter (clear, increment, last-row flag).
REQ-034 The comparator SHALL stay external and be shared; this block instantiates no comparator.

Verification
REQ-035 Matrix row3=0x10, pos1=0x10, pos2=0x01, others 0x00 -> done at cycle 25, hitjug1=1 row=3, hitjug2=0.
REQ-036 Rows 2 and 6 = 0x81, pos1=pos2=0x81 -> both hits, both rows=2 (first match kept).
REQ-037 start_In held high for 30 cycles -> exactly one scan, one done pulse, then a second scan accepted from IDLE.
REQ-038 pos1 changed 0x10->0x20 at cycle 5 of scan, row3=0x10 -> hitjug1=1 row=3.
REQ-039 RESET_InLow low at cycle 12 -> busy, done, hits, rowsel, cmpA/B immediately 0; next start gives a full 25-cycle scan.
REQ-040 All rows 0x00, pos1=0x00, pos2=0xFF -> hitjug1=1 row=0, hitjug2=0; cmpA/cmpB=0 outside CMP states.
